// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolve signal bundle for branch_predict_unit.
// The core-side (master) drives PCs and resolve data; the unit (slave) returns predictions.
interface branch_predict_unit_if #(
  parameter int unsigned STAT_W = 32
);
  logic [31:0]       lk_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              res_valid;
  logic [31:0]       res_pc;
  logic [2:0]        res_funct3;
  logic [31:0]       res_rs1;
  logic [31:0]       res_rs2;
  logic [31:0]       res_target;
  logic              res_pred_taken;
  logic [31:0]       res_pred_target;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic              res_illegal;
  logic [STAT_W-1:0] n_branches;
  logic [STAT_W-1:0] n_mispredicts;

  modport master (
    output lk_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2, res_target,
           res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, res_illegal,
           n_branches, n_mispredicts
  );

  modport slave (
    input  lk_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2, res_target,
           res_pred_taken, res_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, res_illegal,
           n_branches, n_mispredicts
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target table with saturating counters, RV32I branch resolution,
// misprediction detection and saturating performance counters.
module branch_predict_unit #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned STAT_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = TAG_LO + TAG_W - 1;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic              mispredict_q;
  logic              illegal_q;
  logic [31:0]       redirect_q;
  logic [STAT_W-1:0] n_branches_q;
  logic [STAT_W-1:0] n_mispredicts_q;

  // Low two PC bits and bits above the tag never take part in indexing or matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lk_pc, bus.res_pc};

  // ---------------------------------------------------------------------------------------------
  // Lookup: pure read of the registered table, no bypass from a same-cycle update.
  // ---------------------------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = bus.lk_pc[IDX_W+1:2];
  assign lk_tag = bus.lk_pc[TAG_HI:TAG_LO];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bus.pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign bus.pred_target = bus.pred_taken ? target_q[lk_idx] : bus.lk_pc + 32'd4;

  // ---------------------------------------------------------------------------------------------
  // Resolve
  // ---------------------------------------------------------------------------------------------
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic [CNT_W-1:0] res_cnt;
  logic             res_taken;
  logic             res_legal;
  logic [31:0]      res_next;
  logic             res_mispred;
  logic             res_update;
  logic [CNT_W-1:0] cnt_new;

  assign res_idx = bus.res_pc[IDX_W+1:2];
  assign res_tag = bus.res_pc[TAG_HI:TAG_LO];
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
  assign res_cnt = cnt_q[res_idx];

  always_comb begin
    res_taken = 1'b0;
    res_legal = 1'b1;
    case (bus.res_funct3)
      3'b000:  res_taken = (bus.res_rs1 == bus.res_rs2);
      3'b001:  res_taken = (bus.res_rs1 != bus.res_rs2);
      3'b100:  res_taken = ($signed(bus.res_rs1) <  $signed(bus.res_rs2));
      3'b101:  res_taken = ($signed(bus.res_rs1) >= $signed(bus.res_rs2));
      3'b110:  res_taken = (bus.res_rs1 <  bus.res_rs2);
      3'b111:  res_taken = (bus.res_rs1 >= bus.res_rs2);
      default: res_legal = 1'b0;
    endcase
  end

  assign res_next    = res_taken ? bus.res_target : bus.res_pc + 32'd4;
  assign res_mispred = (res_taken != bus.res_pred_taken) ||
                       (res_taken && (bus.res_target != bus.res_pred_target));
  assign res_update  = bus.res_valid && res_legal;

  // A miss allocates at the weak state matching the outcome; a hit steps and saturates.
  always_comb begin
    cnt_new = res_taken ? CNT_WEAK_T : CNT_WEAK_NT;
    if (res_hit) begin
      if (res_taken) begin
        cnt_new = (res_cnt == CNT_MAX) ? res_cnt : res_cnt + CNT_W'(1);
      end else begin
        cnt_new = (res_cnt == '0) ? res_cnt : res_cnt - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      mispredict_q    <= 1'b0;
      illegal_q       <= 1'b0;
      redirect_q      <= '0;
      n_branches_q    <= '0;
      n_mispredicts_q <= '0;
    end else begin
      mispredict_q <= res_update && res_mispred;
      illegal_q    <= bus.res_valid && !res_legal;
      if (res_update) begin
        redirect_q       <= res_next;
        valid_q[res_idx] <= 1'b1;
        tag_q[res_idx]   <= res_tag;
        cnt_q[res_idx]   <= cnt_new;
        if (res_taken || !res_hit) begin
          target_q[res_idx] <= bus.res_target;
        end
        if (n_branches_q != '1) begin
          n_branches_q <= n_branches_q + STAT_W'(1);
        end
        if (res_mispred && (n_mispredicts_q != '1)) begin
          n_mispredicts_q <= n_mispredicts_q + STAT_W'(1);
        end
      end
    end
  end

  assign bus.mispredict    = mispredict_q;
  assign bus.res_illegal   = illegal_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.n_branches    = n_branches_q;
  assign bus.n_mispredicts = n_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and random checks of branch_predict_unit against a table model kept in the bench.
module tb_branch_predict_unit;
  localparam int ENT  = 16;
  localparam int IW   = 4;
  localparam int CW   = 2;
  localparam int TW   = 8;
  localparam int SW   = 6;
  localparam int SMAX = (1 << SW) - 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  branch_predict_unit_if #(.STAT_W(SW)) bus ();

  branch_predict_unit #(
    .ENTRIES(ENT),
    .CNT_W  (CW),
    .TAG_W  (TW),
    .STAT_W (SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays and integer counters.
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  int          m_nb;
  int          m_nm;

  function automatic void m_clear();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_cnt[i]   = 0;
    end
    m_nb = 0;
    m_nm = 0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENT)) % (1 << TW);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[idx_of(pc)] >= (1 << (CW - 1)));
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  // -1 for reserved encodings, else 0/1.
  function automatic int branch_eval(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0:    return int'(a == b);
      3'd1:    return int'(a != b);
      3'd4:    return int'($signed(a) < $signed(b));
      3'd5:    return int'($signed(a) >= $signed(b));
      3'd6:    return int'(a < b);
      3'd7:    return int'(a >= b);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
    chk("n_branches", 64'(bus.n_branches), 64'(m_nb));
    chk("n_mispredicts", 64'(bus.n_mispredicts), 64'(m_nm));
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.lk_pc     = pc;
    bus.res_valid = 1'b0;
    #1;
    chk("lk_taken", 64'(bus.pred_taken), 64'(m_pred(pc)));
    chk("lk_target", 64'(bus.pred_target), 64'(m_ptgt(pc)));
    @(posedge clk);
    #1;
    chk("idle_mispredict", 64'(bus.mispredict), 64'd0);
    chk("idle_illegal", 64'(bus.res_illegal), 64'd0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] tgt, input bit ptk,
                         input logic [31:0] ptg);
    int          t;
    int          i;
    bit          tk;
    bit          e_mis;
    logic [31:0] e_redir;
    bus.lk_pc           = pc;
    bus.res_valid       = 1'b1;
    bus.res_pc          = pc;
    bus.res_funct3      = f3;
    bus.res_rs1         = a;
    bus.res_rs2         = b;
    bus.res_target      = tgt;
    bus.res_pred_taken  = ptk;
    bus.res_pred_target = ptg;
    #1;
    // Same-cycle lookup must see the table before this update.
    chk("lk_taken_old", 64'(bus.pred_taken), 64'(m_pred(pc)));
    chk("lk_target_old", 64'(bus.pred_target), 64'(m_ptgt(pc)));
    t       = branch_eval(f3, a, b);
    tk      = (t == 1);
    e_mis   = 0;
    e_redir = tk ? tgt : pc + 32'd4;
    if (t >= 0) begin
      e_mis = (tk != ptk) || (tk && (tgt != ptg));
      i = idx_of(pc);
      if (m_hit(pc)) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] == (1 << CW) - 1) ? m_cnt[i] : m_cnt[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else begin
        m_valid[i] = 1;
        m_tag[i]   = tag_of(pc);
        m_tgt[i]   = tgt;
        m_cnt[i]   = tk ? (1 << (CW - 1)) : (1 << (CW - 1)) - 1;
      end
      if (m_nb < SMAX) m_nb++;
      if (e_mis && m_nm < SMAX) m_nm++;
    end
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    chk("mispredict", 64'(bus.mispredict), 64'(e_mis));
    chk("res_illegal", 64'(bus.res_illegal), 64'(t < 0));
    if (e_mis) chk("redirect_pc", 64'(bus.redirect_pc), 64'(e_redir));
    chk_stats();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.res_valid = 1'b0;
    m_clear();
    chk("rst_mispredict", 64'(bus.mispredict), 64'd0);
    chk("rst_illegal", 64'(bus.res_illegal), 64'd0);
    chk("rst_redirect", 64'(bus.redirect_pc), 64'd0);
    chk_stats();
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tg;
    logic [31:0] pt;
    bit          pk;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.lk_pc           = '0;
    bus.res_valid       = 1'b0;
    bus.res_pc          = '0;
    bus.res_funct3      = '0;
    bus.res_rs1         = '0;
    bus.res_rs2         = '0;
    bus.res_target      = '0;
    bus.res_pred_taken  = 1'b0;
    bus.res_pred_target = '0;
    m_clear();
    @(posedge clk);
    do_reset();

    // Empty table.
    lookup(32'h0);
    lookup(32'h8);

    // BGEU not taken, then BGEU taken and mispredicted.
    resolve(32'h0, 3'b111, 32'd0, 32'd1, 32'h34, 1'b0, 32'h4);
    resolve(32'h8, 3'b111, 32'd1, 32'd0, 32'h18, 1'b0, 32'hc);
    lookup(32'h8);

    // Signed/unsigned split; predicting not-taken makes mispredict reflect the outcome.
    for (int k = 0; k < 8; k++) begin
      pc = 32'h20 + 32'(k) * 4;
      resolve(pc, 3'(k), 32'hffffffff, 32'h0, 32'h400, 1'b0, pc + 32'd4);
    end
    resolve(32'h80, 3'b000, 32'h55, 32'h55, 32'h300, 1'b0, 32'h84);
    resolve(32'h84, 3'b001, 32'h55, 32'h55, 32'h300, 1'b0, 32'h88);

    // Counter saturation and decay.
    for (int k = 0; k < 5; k++) begin
      resolve(32'h100, 3'b000, 32'd7, 32'd7, 32'h200, m_pred(32'h100), m_ptgt(32'h100));
    end
    resolve(32'h100, 3'b001, 32'd7, 32'd7, 32'h200, m_pred(32'h100), m_ptgt(32'h100));
    lookup(32'h100);
    resolve(32'h100, 3'b001, 32'd7, 32'd7, 32'h200, m_pred(32'h100), m_ptgt(32'h100));
    lookup(32'h100);

    // Aliasing eviction, then illegal funct3 leaves everything alone.
    resolve(32'h40, 3'b000, 32'd1, 32'd1, 32'h90, 1'b0, 32'h44);
    lookup(32'h0);
    lookup(32'h40);
    resolve(32'h40, 3'b010, 32'd1, 32'd2, 32'h999, 1'b0, 32'h44);
    resolve(32'h40, 3'b011, 32'd1, 32'd1, 32'h999, 1'b1, 32'h999);
    lookup(32'h40);

    // PC wrap on the fall-through path.
    resolve(32'hfffffffc, 3'b001, 32'd3, 32'd3, 32'h1234, 1'b1, 32'h1234);

    // Drive both statistics into saturation.
    for (int k = 0; k < SMAX + 8; k++) begin
      pc = 32'h200 + 32'(k % 8) * 4;
      resolve(pc, 3'b000, 32'd9, 32'd9, 32'h600, 1'b0, pc + 32'd4);
    end
    lookup(32'h200);

    // Random traffic with aliasing PCs and occasional corrupted predictions.
    for (int k = 0; k < 300; k++) begin
      pc = (32'($urandom_range(0, 47)) << 2) | (($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      tg = {$urandom_range(0, 255), 2'b00};
      pk = m_pred(pc);
      pt = m_ptgt(pc);
      if ($urandom_range(0, 9) < 3) begin
        pk = 1'($urandom_range(0, 1));
        pt = ($urandom_range(0, 1) == 1) ? tg : {$urandom_range(0, 255), 2'b00};
      end
      if ($urandom_range(0, 7) == 0) lookup(pc);
      else resolve(pc, 3'($urandom_range(0, 7)), a, b, tg, pk, pt);
    end

    // Reset coinciding with a mispredicting resolve: update dropped, no pulse.
    bus.lk_pc           = 32'h8;
    bus.res_valid       = 1'b1;
    bus.res_pc          = 32'h8;
    bus.res_funct3      = 3'b000;
    bus.res_rs1         = 32'd1;
    bus.res_rs2         = 32'd1;
    bus.res_target      = 32'h80;
    bus.res_pred_taken  = 1'b0;
    bus.res_pred_target = 32'hc;
    do_reset();
    for (int k = 0; k < ENT; k++) lookup(32'(k) * 4);
    lookup(32'h1008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
